// File: rtl/uart_pixel_rx_pkg.sv
// Shared types and constants for the UART pixel receiver.
// Build option: define RX_PARITY_EN for an 8E1 frame with an even-parity bit.
package uart_pixel_rx_pkg;

    localparam int unsigned TICK_PER_HALF_DEF = 2604;
    localparam int unsigned BPP_DEF           = 3;
    localparam int unsigned HIEGHT_DEF        = 30;
    localparam int unsigned WIDTH_DEF         = 30;

    function automatic int unsigned pixels_f(input int unsigned h, input int unsigned w);
        return h * w;
    endfunction

    function automatic int unsigned sz_f(input int unsigned bpp);
        return 8 * bpp - 1;
    endfunction

    // At least one address bit, even for a single-pixel image
    function automatic int unsigned addr_w_f(input int unsigned pixels);
        return (pixels > 1) ? $clog2(pixels) : 1;
    endfunction

    localparam int unsigned PIXELS = pixels_f(HIEGHT_DEF, WIDTH_DEF);
    localparam int unsigned SZ     = sz_f(BPP_DEF);
    localparam int unsigned ADDR_W = addr_w_f(PIXELS);

`ifdef RX_PARITY_EN
    typedef enum logic [2:0] {B_IDLE, B_START, B_DATA, B_PARITY, B_STOP} byte_state_e;
`else
    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} byte_state_e;
`endif

    typedef enum logic [1:0] {TOP_WAIT, TOP_ARMED, TOP_FULL} top_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: synchronizer, start-bit qualification, LSB-first data, stop check.
// Build option: RX_PARITY_EN adds an even-parity bit after bit 7.
module uart_rx_byte
    import uart_pixel_rx_pkg::*;
#(
    parameter int unsigned TICK_PER_HALF = TICK_PER_HALF_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       armed,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_err,
    output logic       rx_active
);

    localparam int unsigned BIT_T = 2 * TICK_PER_HALF;
    localparam int unsigned CNT_W = (BIT_T > 1) ? $clog2(BIT_T) : 1;
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(TICK_PER_HALF - 1);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(BIT_T - 1);

    byte_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             rx_s1_q, rx_s2_q, rx_prev_q;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             active_q, active_d;
    logic [7:0]       data_q;
`ifdef RX_PARITY_EN
    logic             par_bad_q, par_bad_d;
`endif

    // Two-flop synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= B_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            active_q  <= 1'b0;
            data_q    <= '0;
`ifdef RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            active_q  <= active_d;
            if (valid_d) data_q <= shift_q;
`ifdef RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_d     = bit_q;
        shift_d   = shift_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
`ifdef RX_PARITY_EN
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            B_IDLE: begin
                cnt_d = '0;
                if (armed && rx_prev_q && !rx_s2_q) state_d = B_START;
            end
            // A start bit that is high again at mid-bit was a glitch
            B_START: begin
                if (cnt_q == HALF_END) begin
                    cnt_d     = '0;
                    bit_d     = '0;
`ifdef RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                    state_d   = rx_s2_q ? B_IDLE : B_DATA;
                end
            end
            B_DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    shift_d = {rx_s2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef RX_PARITY_EN
                        state_d = B_PARITY;
`else
                        state_d = B_STOP;
`endif
                    end
                end
            end
`ifdef RX_PARITY_EN
            B_PARITY: begin
                if (cnt_q == BIT_END) begin
                    cnt_d     = '0;
                    par_bad_d = rx_s2_q ^ (^shift_q);
                    state_d   = B_STOP;
                end
            end
`endif
            B_STOP: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    state_d = B_IDLE;
`ifdef RX_PARITY_EN
                    if (rx_s2_q && !par_bad_q) valid_d = 1'b1;
`else
                    if (rx_s2_q) valid_d = 1'b1;
`endif
                    else err_d = 1'b1;
                end
            end
            default: state_d = B_IDLE;
        endcase
        active_d = (state_d != B_IDLE);
    end

    assign byte_valid = valid_q;
    assign byte_data  = data_q;
    assign byte_err   = err_q;
    assign rx_active  = active_q;

endmodule

// File: rtl/uart_pixel_rx.sv
// Receives one frame of HIEGHT*WIDTH pixels over UART and emits pixel write strobes.
// Build option: RX_PARITY_EN (passed through to the byte receiver).
module uart_pixel_rx
    import uart_pixel_rx_pkg::*;
#(
    parameter  int unsigned TICK_PER_HALF = TICK_PER_HALF_DEF,
    parameter  int unsigned BPP           = BPP_DEF,
    parameter  int unsigned HIEGHT        = HIEGHT_DEF,
    parameter  int unsigned WIDTH         = WIDTH_DEF,
    localparam int unsigned NPIX          = pixels_f(HIEGHT, WIDTH),
    localparam int unsigned AW            = addr_w_f(NPIX),
    localparam int unsigned DW            = sz_f(BPP) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          rx,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          rx_active,
    output logic          done,
    output logic          frame_err
);

    localparam int unsigned CW = (BPP > 1) ? $clog2(BPP) : 1;

    top_state_e    top_q, top_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] pix_q, pix_d;
    logic [DW-1:0] data_q, data_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          wr_en_q, wr_en_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          byte_valid, byte_err;
    logic [7:0]    byte_data;

    uart_rx_byte #(.TICK_PER_HALF(TICK_PER_HALF)) u_byte (
        .clk        (clk),
        .rst        (rst),
        .armed      (top_q == TOP_ARMED),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_err   (byte_err),
        .rx_active  (rx_active)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            top_q   <= TOP_WAIT;
            cnt_q   <= '0;
            pix_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            top_q   <= top_d;
            cnt_q   <= cnt_d;
            pix_q   <= pix_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            wr_en_q <= wr_en_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        top_d   = top_q;
        cnt_d   = cnt_q;
        pix_d   = pix_q;
        data_d  = data_q;
        addr_d  = addr_q;
        wr_en_d = 1'b0;
        done_d  = done_q;
        err_d   = err_q;
        case (top_q)
            TOP_WAIT, TOP_FULL: begin
                if (start) begin
                    top_d  = TOP_ARMED;
                    cnt_d  = '0;
                    pix_d  = '0;
                    addr_d = '0;
                    done_d = 1'b0;
                    err_d  = 1'b0;
                end
            end
            TOP_ARMED: begin
                // Address advances after the write cycle so it is stable during wr_en
                if (wr_en_q) addr_d = addr_q + AW'(1);
                if (byte_err) begin
                    err_d = 1'b1;
                    cnt_d = '0;
                    pix_d = '0;
                end else if (byte_valid) begin
                    if (cnt_q == CW'(BPP - 1)) begin
                        wr_en_d = 1'b1;
                        data_d  = DW'({pix_q, byte_data});
                        cnt_d   = '0;
                        pix_d   = '0;
                        if (addr_q == AW'(NPIX - 1)) begin
                            done_d = 1'b1;
                            top_d  = TOP_FULL;
                        end
                    end else begin
                        pix_d = DW'({pix_q, byte_data});
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: top_d = TOP_WAIT;
        endcase
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = addr_q;
    assign wr_data   = data_q;
    assign done      = done_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_uart_pixel_rx.sv
// Self-checking bench for uart_pixel_rx (TICK_PER_HALF=4, 2x2 image, 3 bytes per pixel).
// Honours RX_PARITY_EN when the design is built with it.
module tb_uart_pixel_rx;

    localparam int unsigned TPH      = 4;
    localparam int unsigned BPP      = 3;
    localparam int unsigned H        = 2;
    localparam int unsigned W        = 2;
    localparam int unsigned NPIX     = H * W;
    localparam int unsigned AW       = 2;
    localparam int unsigned DW       = 8 * BPP;
    localparam int unsigned BIT_CLKS = 2 * TPH;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          rx;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rx_active;
    logic          done;
    logic          frame_err;

    uart_pixel_rx #(.TICK_PER_HALF(TPH), .BPP(BPP), .HIEGHT(H), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rx        (rx),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rx_active (rx_active),
        .done      (done),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Write monitor
    int            wr_cnt = 0;
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_data = '0;
    logic          prev_wr = 1'b0;

    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt++;
            last_addr = wr_addr;
            last_data = wr_data;
            checks++;
            if (prev_wr) begin
                errors++;
                $display("FAIL wr_en_width: got 2+ cycles expected 1 cycle");
            end
        end
        prev_wr = wr_en;
    end

    // Reference model: frame bookkeeping from the protocol rules
    bit            m_armed = 1'b0;
    bit            m_done = 1'b0;
    bit            m_err = 1'b0;
    int            m_addr = 0;
    logic [7:0]    m_pix[$];
    bit            m_wr_exp = 1'b0;
    int            m_wr_addr = 0;
    logic [DW-1:0] m_wr_data = '0;

    task automatic model_reset();
        m_armed = 1'b0; m_done = 1'b0; m_err = 1'b0; m_addr = 0; m_pix.delete();
    endtask

    task automatic model_start();
        if (!m_armed) begin
            m_armed = 1'b1; m_done = 1'b0; m_err = 1'b0; m_addr = 0; m_pix.delete();
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input bit good);
        m_wr_exp = 1'b0;
        if (!m_armed) return;
        if (!good) begin
            m_err = 1'b1;
            m_pix.delete();
            return;
        end
        m_pix.push_back(b);
        if (m_pix.size() == BPP) begin
            m_wr_exp  = 1'b1;
            m_wr_addr = m_addr;
            m_wr_data = '0;
            foreach (m_pix[k]) m_wr_data = (m_wr_data << 8) | DW'(m_pix[k]);
            m_pix.delete();
            if (m_addr == NPIX - 1) begin
                m_done  = 1'b1;
                m_armed = 1'b0;
            end else begin
                m_addr++;
            end
        end
    endtask

    // Serial driver; data LSB-first, optional even parity, then stop bit
    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit par_ok);
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
`ifdef RX_PARITY_EN
        rx = (^b) ^ !par_ok;
        repeat (BIT_CLKS) @(negedge clk);
`endif
        rx = stop_ok;
        repeat (BIT_CLKS) @(negedge clk);
        rx = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_start();
        @(negedge clk);
    endtask

    task automatic byte_and_check(input string tag, input logic [7:0] b, input bit stop_ok, input bit par_ok);
        int wb;
        wb = wr_cnt;
        send_byte(b, stop_ok, par_ok);
        model_byte(b, stop_ok && par_ok);
        chk({tag, "_wr_count"}, 32'(wr_cnt - wb), 32'(m_wr_exp));
        if (m_wr_exp) begin
            chk({tag, "_wr_addr"}, 32'(last_addr), 32'(m_wr_addr));
            chk({tag, "_wr_data"}, 32'(last_data), 32'(m_wr_data));
        end
        chk({tag, "_done"}, 32'(done), 32'(m_done));
        chk({tag, "_frame_err"}, 32'(frame_err), 32'(m_err));
        chk({tag, "_addr_now"}, 32'(wr_addr), 32'(m_addr));
        chk({tag, "_rx_active"}, 32'(rx_active), 32'd0);
    endtask

    typedef struct {
        logic [7:0]    data;
        bit            exp_wr;
        int            exp_addr;
        logic [DW-1:0] exp_data;
        bit            exp_done;
    } vec_t;

    vec_t          vecs[12];
    logic [DW-1:0] px[4] = '{24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         wb;
        logic [7:0] rb;
        bit         good;
        bit         pgood;

        for (int i = 0; i < 12; i++) begin
            vecs[i].data     = 8'(i + 1);
            vecs[i].exp_wr   = (i % 3 == 2);
            vecs[i].exp_addr = i / 3;
            vecs[i].exp_data = px[i / 3];
            vecs[i].exp_done = (i == 11);
        end

        rst = 1'b0; start = 1'b0; rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_rx_active", 32'(rx_active), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b1;
        model_reset();
        @(negedge clk);

        byte_and_check("no_start", 8'h11, 1'b1, 1'b1);

        pulse_start();
        wb = wr_cnt;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch_wr_count", 32'(wr_cnt - wb), 32'd0);
        chk("glitch_frame_err", 32'(frame_err), 32'd0);
        chk("glitch_rx_active", 32'(rx_active), 32'd0);

        byte_and_check("partial_good", 8'h99, 1'b1, 1'b1);
        byte_and_check("bad_stop", 8'h55, 1'b0, 1'b1);
        byte_and_check("after_err0", 8'hA1, 1'b1, 1'b1);
        byte_and_check("after_err1", 8'hB2, 1'b1, 1'b1);
        byte_and_check("after_err2", 8'hC3, 1'b1, 1'b1);

        pulse_start();
        chk("start_armed_err_kept", 32'(frame_err), 32'd1);
        chk("start_armed_addr_kept", 32'(wr_addr), 32'd1);
        for (int i = 0; i < 9; i++) byte_and_check($sformatf("fill%0d", i), 8'(8'h20 + i), 1'b1, 1'b1);

        pulse_start();
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_frame_err", 32'(frame_err), 32'd0);
        chk("restart_addr", 32'(wr_addr), 32'd0);
        for (int i = 0; i < 12; i++) begin
            wb = wr_cnt;
            send_byte(vecs[i].data, 1'b1, 1'b1);
            model_byte(vecs[i].data, 1'b1);
            chk($sformatf("vec%0d_wr_count", i), 32'(wr_cnt - wb), 32'(vecs[i].exp_wr));
            if (vecs[i].exp_wr) begin
                chk($sformatf("vec%0d_wr_addr", i), 32'(last_addr), 32'(vecs[i].exp_addr));
                chk($sformatf("vec%0d_wr_data", i), 32'(last_data), 32'(vecs[i].exp_data));
            end
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].exp_done));
        end
        chk("frame_frame_err", 32'(frame_err), 32'd0);
        chk("frame_addr_held", 32'(wr_addr), 32'd3);

        for (int i = 0; i < 3; i++) byte_and_check($sformatf("full%0d", i), 8'(8'hE0 + i), 1'b1, 1'b1);
        pulse_start();
        chk("rearm_done", 32'(done), 32'd0);
        for (int i = 0; i < 3; i++) byte_and_check($sformatf("rearm%0d", i), 8'(8'h30 + i), 1'b1, 1'b1);
        chk("rearm_wr_addr", 32'(last_addr), 32'd0);

        byte_and_check("pre_rst", 8'h77, 1'b1, 1'b1);
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = 1'(i & 1);
            repeat (BIT_CLKS) @(negedge clk);
        end
        chk("mid_byte_rx_active", 32'(rx_active), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_wr_en", 32'(wr_en), 32'd0);
        chk("async_rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("async_rst_wr_data", 32'(wr_data), 32'd0);
        chk("async_rst_rx_active", 32'(rx_active), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        chk("async_rst_frame_err", 32'(frame_err), 32'd0);
        rx = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) byte_and_check($sformatf("post_rst%0d", i), 8'(8'h40 + i), 1'b1, 1'b1);

`ifdef RX_PARITY_EN
        pulse_start();
        byte_and_check("parity_bad", 8'hA5, 1'b1, 1'b0);
        byte_and_check("parity_ok0", 8'hA5, 1'b1, 1'b1);
        byte_and_check("parity_ok1", 8'h5A, 1'b1, 1'b1);
        byte_and_check("parity_ok2", 8'h3C, 1'b1, 1'b1);
`endif

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) == 0 || n == 0) pulse_start();
            rb    = 8'($urandom);
            good  = ($urandom_range(0, 7) != 0);
            pgood = 1'b1;
`ifdef RX_PARITY_EN
            pgood = ($urandom_range(0, 7) != 0);
`endif
            byte_and_check($sformatf("rand%0d", n), rb, good, pgood);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
